// File: rtl/intra_pkg.sv
// Shared definitions for the intra reconstruction write-back path.
// Holds the default sample width, the sample-address width, the block row count
// and the layout of one buffered 4x4 block (samples in the LSBs, base address on top).
package intra_pkg;

  localparam int unsigned BIT_DEPTH_Y     = 10;
  localparam int unsigned ADDR_W          = 27;
  localparam int unsigned ROWS_PER_BLK    = 4;
  localparam int unsigned SAMPLES_PER_ROW = 4;
  localparam int unsigned SAMPLES_PER_BLK = ROWS_PER_BLK * SAMPLES_PER_ROW;

  // Buffered block at the default sample width.
  typedef struct packed {
    logic [ADDR_W-1:0]                      base;
    logic [SAMPLES_PER_BLK*BIT_DEPTH_Y-1:0] data;
  } recon_entry_t;

  // Width of a buffered block for an arbitrary sample width; same layout as recon_entry_t.
  function automatic int unsigned entry_w(int unsigned bit_depth);
    return SAMPLES_PER_BLK * bit_depth + ADDR_W;
  endfunction

endpackage

// File: rtl/recon_row_writer_if.sv
// Bus bundle for recon_row_writer.
// Block input side : recon_val/recon_rdy handshake, 16 samples, CTB position, picture size.
// Memory side      : mem_wr_val/mem_wr_rdy handshake, row address and row data.
// Status           : busy.
// slave  = the row writer, master = the block producer / memory model.
interface recon_row_writer_if #(
  parameter int unsigned bitDepthY = intra_pkg::BIT_DEPTH_Y
);
  logic                                     recon_val;
  logic                                     recon_rdy;
  logic [16*bitDepthY-1:0]                  r_reconSamples;
  logic [8:0]                               xCtb;
  logic [8:0]                               yCtb;
  logic [3:0]                               xTb_rela;
  logic [3:0]                               yTb_rela;
  logic [2:0]                               nMaxCUlog2;
  logic [13:0]                              pic_width_in_luma_samples;
  logic [12:0]                              pic_height_in_luma_samples;
  logic                                     mem_wr_val;
  logic                                     mem_wr_rdy;
  logic [intra_pkg::ADDR_W-1:0]             mem_wr_addr;
  logic [4*bitDepthY-1:0]                   mem_wr_data;
  logic                                     busy;

  modport slave (
    input  recon_val, r_reconSamples, xCtb, yCtb, xTb_rela, yTb_rela, nMaxCUlog2,
    input  pic_width_in_luma_samples, pic_height_in_luma_samples, mem_wr_rdy,
    output recon_rdy, mem_wr_val, mem_wr_addr, mem_wr_data, busy
  );

  modport master (
    output recon_val, r_reconSamples, xCtb, yCtb, xTb_rela, yTb_rela, nMaxCUlog2,
    output pic_width_in_luma_samples, pic_height_in_luma_samples, mem_wr_rdy,
    input  recon_rdy, mem_wr_val, mem_wr_addr, mem_wr_data, busy
  );
endinterface

// File: rtl/recon_blk_fifo.sv
// Synchronous FIFO of whole reconstructed blocks.
// Ports: clk_i/rst_i (sync, active-high); push_i/push_data_i write the tail;
// pop_i drops the head; head_o is the head entry, next_o the entry behind it
// (valid when count_o >= 2); count_o/full_o/empty_o report occupancy.
// Depth must be a power of two so the pointers wrap for free.
module recon_blk_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic [Width-1:0] next_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [CntW-1:0]  count_q;

  assign rd_nxt = rd_ptr_q + PtrW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_q <= rd_nxt;
      if (push_i && !pop_i)      count_q <= count_q + CntW'(1);
      else if (pop_i && !push_i) count_q <= count_q - CntW'(1);
    end
  end

  // Storage carries no reset; it is only read once an entry has been written.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[rd_nxt];
  assign count_o = count_q;
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/recon_row_writer.sv
// Reconstruction row writer: accepts 4x4 luma blocks, computes their picture
// sample address, buffers them and writes them to memory one 4-sample row per beat.
// Ports: clk, rst (sync, active-high); bus (recon_row_writer_if.slave) carries the
// block handshake and position inputs, the memory write handshake, and busy.
// Blocks lying outside the picture are accepted and dropped.
module recon_row_writer
  import intra_pkg::*;
#(
  parameter int unsigned bitDepthY  = BIT_DEPTH_Y,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  recon_row_writer_if.slave       bus
);

  localparam int unsigned RowW   = SAMPLES_PER_ROW * bitDepthY;
  localparam int unsigned EntryW = entry_w(bitDepthY);
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StWrite = 1'b1;

  // Address arithmetic, done at acceptance.
  logic [ADDR_W-1:0] pic_w, pic_h, blk_x, blk_y, blk_base;
  logic              in_pic;

  assign pic_w    = ADDR_W'(bus.pic_width_in_luma_samples);
  assign pic_h    = ADDR_W'(bus.pic_height_in_luma_samples);
  assign blk_x    = (ADDR_W'(bus.xCtb) << bus.nMaxCUlog2) + (ADDR_W'(bus.xTb_rela) << 2);
  assign blk_y    = (ADDR_W'(bus.yCtb) << bus.nMaxCUlog2) + (ADDR_W'(bus.yTb_rela) << 2);
  assign blk_base = blk_y * pic_w + blk_x;
  assign in_pic   = (blk_x < pic_w) && (blk_y < pic_h);

  // Block buffer.
  logic              fifo_full, fifo_empty, push, pop, accept;
  logic [CntW-1:0]   fifo_count;
  logic [EntryW-1:0] push_entry, fifo_head, fifo_next;

  assign bus.recon_rdy = ~fifo_full;
  assign accept        = bus.recon_val & ~fifo_full;
  assign push          = accept & in_pic;
  assign push_entry    = {blk_base, bus.r_reconSamples};

  recon_blk_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .next_o      (fifo_next),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  function automatic logic [RowW-1:0] row_of(logic [EntryW-1:0] e, logic [1:0] r);
    return e[int'(r)*RowW +: RowW];
  endfunction

  function automatic logic [ADDR_W-1:0] base_of(logic [EntryW-1:0] e);
    return e[EntryW-1 -: ADDR_W];
  endfunction

  // Drain state machine with registered write outputs.
  logic [0:0]        state_q, state_d;
  logic [1:0]        row_q, row_d;
  logic              val_q, val_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RowW-1:0]   data_q, data_d;
  logic              wr_hs, wr_last, nxt_avail;
  logic [EntryW-1:0] nxt_entry;

  assign wr_hs   = val_q & bus.mem_wr_rdy;
  assign wr_last = wr_hs & (row_q == 2'(ROWS_PER_BLK - 1));
  assign pop     = wr_last;

  // Block that follows the head: the second FIFO entry, or the block being pushed
  // this cycle when the head is the only one buffered, so there is no bubble.
  assign nxt_avail = (fifo_count > CntW'(1)) | push;
  assign nxt_entry = (fifo_count > CntW'(1)) ? fifo_next : push_entry;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    val_d   = val_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StWrite;
          val_d   = 1'b1;
          row_d   = '0;
          addr_d  = base_of(fifo_head);
          data_d  = row_of(fifo_head, 2'd0);
        end
      end
      StWrite: begin
        if (wr_hs) begin
          if (!wr_last) begin
            row_d  = row_q + 2'd1;
            addr_d = addr_q + pic_w;
            data_d = row_of(fifo_head, row_q + 2'd1);
          end else if (nxt_avail) begin
            row_d  = '0;
            addr_d = base_of(nxt_entry);
            data_d = row_of(nxt_entry, 2'd0);
          end else begin
            state_d = StIdle;
            val_d   = 1'b0;
            row_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      val_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      val_q   <= val_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign bus.mem_wr_val  = val_q;
  assign bus.mem_wr_addr = addr_q;
  assign bus.mem_wr_data = data_q;
  assign bus.busy        = ~fifo_empty;

endmodule

// File: tb/tb_recon_row_writer.sv
module tb_recon_row_writer;
  localparam int BD   = 10;
  localparam int FD   = 4;
  localparam int RowW = 4 * BD;

  typedef struct {
    logic [26:0]     addr;
    logic [RowW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   writes_seen = 0;

  recon_row_writer_if #(.bitDepthY(BD)) bus ();

  recon_row_writer #(
    .bitDepthY  (BD),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of every row write still owed, in order.
  exp_t            exp_q[$];
  exp_t            e;
  bit              exp_rdy, prev_stall;
  logic [26:0]     prev_addr;
  logic [RowW-1:0] prev_data;
  longint          mx, my, mw, mh;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      // Blocks still owning unwritten rows are the ones held in the buffer.
      exp_rdy = ((exp_q.size() + 3) / 4) < FD;
      checks++;
      if (bus.recon_rdy !== exp_rdy) begin
        errors++;
        $display("FAIL recon_rdy at %0t: got %b want %b", $time, bus.recon_rdy, exp_rdy);
      end
      checks++;
      if (bus.busy !== logic'(exp_q.size() != 0)) begin
        errors++;
        $display("FAIL busy at %0t: got %b want %b", $time, bus.busy, exp_q.size() != 0);
      end
      if (prev_stall) begin
        checks++;
        if (bus.mem_wr_val !== 1'b1 || bus.mem_wr_addr !== prev_addr ||
            bus.mem_wr_data !== prev_data) begin
          errors++;
          $display("FAIL hold at %0t: got val=%b addr=%0d data=%h want val=1 addr=%0d data=%h",
                   $time, bus.mem_wr_val, bus.mem_wr_addr, bus.mem_wr_data, prev_addr, prev_data);
        end
      end
      if (bus.mem_wr_val === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write at %0t: got addr=%0d want no write", $time,
                   bus.mem_wr_addr);
        end else begin
          if (bus.mem_wr_addr !== exp_q[0].addr || bus.mem_wr_data !== exp_q[0].data) begin
            errors++;
            $display("FAIL row_write at %0t: got addr=%0d data=%h want addr=%0d data=%h", $time,
                     bus.mem_wr_addr, bus.mem_wr_data, exp_q[0].addr, exp_q[0].data);
          end
          if (bus.mem_wr_rdy === 1'b1) begin
            void'(exp_q.pop_front());
            writes_seen++;
          end
        end
      end
      prev_stall = (bus.mem_wr_val === 1'b1) && (bus.mem_wr_rdy !== 1'b1);
      prev_addr  = bus.mem_wr_addr;
      prev_data  = bus.mem_wr_data;
      if (bus.recon_val === 1'b1 && bus.recon_rdy === 1'b1) begin
        mw = longint'(bus.pic_width_in_luma_samples);
        mh = longint'(bus.pic_height_in_luma_samples);
        mx = longint'(bus.xCtb) * (longint'(1) << bus.nMaxCUlog2) + 4 * longint'(bus.xTb_rela);
        my = longint'(bus.yCtb) * (longint'(1) << bus.nMaxCUlog2) + 4 * longint'(bus.yTb_rela);
        if (mx < mw && my < mh) begin
          for (int r = 0; r < 4; r++) begin
            e.addr = 27'(my * mw + mx + longint'(r) * mw);
            e.data = bus.r_reconSamples[r*RowW +: RowW];
            exp_q.push_back(e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pic(input int w, input int h);
    bus.pic_width_in_luma_samples  = 14'(w);
    bus.pic_height_in_luma_samples = 13'(h);
  endtask

  task automatic set_block(input int xc, input int yc, input int xt, input int yt, input int n);
    bus.xCtb       = 9'(xc);
    bus.yCtb       = 9'(yc);
    bus.xTb_rela   = 4'(xt);
    bus.yTb_rela   = 4'(yt);
    bus.nMaxCUlog2 = 3'(n);
    for (int i = 0; i < 16; i++) bus.r_reconSamples[i*BD +: BD] = BD'($urandom);
  endtask

  // Holds recon_val until accepted or the cycle budget runs out.
  task automatic offer(input int budget, output bit acc);
    bus.recon_val = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      acc = bus.recon_rdy;
      tick();
      if (acc) break;
    end
    bus.recon_val = 1'b0;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && bus.mem_wr_val === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.recon_val  = 1'b1;
    bus.mem_wr_rdy = 1'b1;
    set_pic(64, 64);
    set_block(0, 0, 0, 0, 6);
    tick();
    tick();
    checks++;
    if (bus.mem_wr_val !== 1'b0 || bus.mem_wr_addr !== '0 || bus.mem_wr_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got val=%b addr=%0d data=%h want 0/0/0", bus.mem_wr_val,
               bus.mem_wr_addr, bus.mem_wr_data);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    rst = 1'b0;
    bus.recon_val = 1'b0;
    tick();
    checks++;
    if (bus.recon_rdy !== 1'b1 || bus.mem_wr_val !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b val=%b busy=%b want 1/0/0", bus.recon_rdy,
               bus.mem_wr_val, bus.busy);
    end
  endtask

  task automatic test_single_block();
    int              exp_addr[4];
    logic [16*BD-1:0] samples;
    logic [RowW-1:0]  row;
    bit               acc;
    exp_addr = '{516, 580, 644, 708};
    set_pic(64, 64);
    bus.mem_wr_rdy = 1'b1;
    set_block(0, 0, 1, 2, 6);
    samples = bus.r_reconSamples;
    offer(4, acc);
    checks++;
    if (acc !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_accept: got acc=%b busy=%b want 1/1", acc, bus.busy);
    end
    for (int r = 0; r < 4; r++) begin
      tick();
      row = samples[r*RowW +: RowW];
      checks++;
      if (bus.mem_wr_val !== 1'b1 || bus.mem_wr_addr !== 27'(exp_addr[r]) ||
          bus.mem_wr_data !== row) begin
        errors++;
        $display("FAIL single_row%0d: got val=%b addr=%0d data=%h want 1 %0d %h", r,
                 bus.mem_wr_val, bus.mem_wr_addr, bus.mem_wr_data, exp_addr[r], row);
      end
    end
    tick();
    checks++;
    if (bus.mem_wr_val !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_end: got val=%b busy=%b want 0/0", bus.mem_wr_val, bus.busy);
    end
  endtask

  task automatic test_clipping();
    bit acc;
    set_pic(72, 64);
    bus.mem_wr_rdy = 1'b1;
    set_block(1, 0, 2, 0, 6);
    offer(4, acc);
    checks++;
    if (acc !== 1'b1) begin
      errors++;
      $display("FAIL clip_accept: got %b want 1", acc);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.mem_wr_val !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL clip_idle: got val=%b busy=%b want 0/0", bus.mem_wr_val, bus.busy);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit acc, ok;
    int start, first_base, x0, y0;
    set_pic(128, 128);
    bus.mem_wr_rdy = 1'b0;
    start = writes_seen;
    for (int b = 0; b < 6; b++) begin
      set_block($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
                $urandom_range(0, 15), 6);
      if (b == 0) begin
        x0 = int'(bus.xCtb) * 64 + int'(bus.xTb_rela) * 4;
        y0 = int'(bus.yCtb) * 64 + int'(bus.yTb_rela) * 4;
        first_base = y0 * 128 + x0;
      end
      offer((b < 4) ? 2 : 3 - (b - 4), acc);
      checks++;
      if (acc !== (b < 4)) begin
        errors++;
        $display("FAIL bp_accept%0d: got %b want %b", b, acc, b < 4);
      end
    end
    tick();
    checks++;
    if (bus.mem_wr_val !== 1'b1 || bus.mem_wr_addr !== 27'(first_base)) begin
      errors++;
      $display("FAIL bp_held: got val=%b addr=%0d want 1 %0d", bus.mem_wr_val, bus.mem_wr_addr,
               first_base);
    end
    bus.mem_wr_rdy = 1'b1;
    wait_drain(60, ok);
    checks++;
    if (!ok || writes_seen - start != 16) begin
      errors++;
      $display("FAIL bp_drain: got drained=%b writes=%0d want 1 16", ok, writes_seen - start);
    end
  endtask

  task automatic test_back_to_back();
    int start;
    set_pic(256, 256);
    bus.mem_wr_rdy = 1'b1;
    start = writes_seen;
    for (int cyc = 0; cyc < 36; cyc++) begin
      if (cyc % 4 == 0 && cyc < 32) begin
        set_block($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15),
                  $urandom_range(0, 15), 6);
        bus.recon_val = 1'b1;
      end else begin
        bus.recon_val = 1'b0;
      end
      @(negedge clk);
      if (bus.recon_val) begin
        checks++;
        if (bus.recon_rdy !== 1'b1) begin
          errors++;
          $display("FAIL stream_rdy cyc %0d: got %b want 1", cyc, bus.recon_rdy);
        end
      end
      if (cyc >= 2 && cyc <= 33) begin
        checks++;
        if (bus.mem_wr_val !== 1'b1) begin
          errors++;
          $display("FAIL stream_gap cyc %0d: got val=%b want 1", cyc, bus.mem_wr_val);
        end
      end
      if (cyc == 34) begin
        checks++;
        if (bus.mem_wr_val !== 1'b0) begin
          errors++;
          $display("FAIL stream_end: got val=%b want 0", bus.mem_wr_val);
        end
      end
      tick();
    end
    checks++;
    if (writes_seen - start != 32) begin
      errors++;
      $display("FAIL stream_count: got %0d want 32", writes_seen - start);
    end
  endtask

  task automatic test_reset_mid_block();
    bit acc;
    int start;
    set_pic(64, 64);
    bus.mem_wr_rdy = 1'b1;
    start = writes_seen;
    set_block(0, 0, 3, 1, 6);
    offer(4, acc);
    for (int i = 0; i < 10 && writes_seen < start + 2; i++) tick();
    rst = 1'b1;
    bus.mem_wr_rdy = 1'b0;
    tick();
    checks++;
    if (bus.mem_wr_val !== 1'b0 || bus.busy !== 1'b0 || bus.recon_rdy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_clear: got val=%b busy=%b rdy=%b want 0/0/1", bus.mem_wr_val,
               bus.busy, bus.recon_rdy);
    end
    rst = 1'b0;
    bus.mem_wr_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (bus.mem_wr_val !== 1'b0) begin
        errors++;
        $display("FAIL midrst_resume: got val=%b want 0", bus.mem_wr_val);
      end
    end
    checks++;
    if (writes_seen - start != 2) begin
      errors++;
      $display("FAIL midrst_rows: got %0d writes want 2", writes_seen - start);
    end
  endtask

  task automatic test_random();
    bit ok;
    int start, n;
    set_pic(200, 120);
    start = writes_seen;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.mem_wr_rdy = ($urandom_range(0, 3) != 0);
      n = $urandom_range(4, 6);
      set_block($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, (1 << n) / 4 - 1),
                $urandom_range(0, (1 << n) / 4 - 1), n);
      bus.recon_val = 1'($urandom_range(0, 1));
      tick();
    end
    bus.recon_val  = 1'b0;
    bus.mem_wr_rdy = 1'b1;
    wait_drain(100, ok);
    checks++;
    if (!ok || writes_seen == start || (writes_seen - start) % 4 != 0) begin
      errors++;
      $display("FAIL random_drain: got drained=%b writes=%0d want 1 and nonzero multiple of 4",
               ok, writes_seen - start);
    end
  endtask

  initial begin
    bus.recon_val      = 1'b0;
    bus.mem_wr_rdy     = 1'b0;
    bus.r_reconSamples = '0;
    set_pic(64, 64);
    set_block(0, 0, 0, 0, 6);
    test_reset();
    test_single_block();
    test_clipping();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_block();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/recon_row_writer.md
RECON_ROW_WRITER -- requirements
Module: recon_row_writer

Interface
REQ-001 Parameter bitDepthY, default 10: sample width in bits.
REQ-002 Parameter FIFO_DEPTH, default 4: number of buffered 4x4 blocks (power of two, at least 2).
REQ-003 clk  in  1  single clock; all logic on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 recon_val  in  1  a 4x4 reconstructed block is presented.
REQ-006 recon_rdy  out  1  block accepted when recon_val and recon_rdy are both high at a rising edge.
REQ-007 r_reconSamples  in  bitDepthY*16  sample i at bits [i*bitDepthY +: bitDepthY]; i = 4*row + col; row 0 is the top row.
REQ-008 xCtb, yCtb  in  9 each  CTB coordinate in CTB units.
REQ-009 xTb_rela, yTb_rela  in  4 each  block offset inside the CTB, in 4-sample units.
REQ-010 nMaxCUlog2  in  3  CTB size log2; legal values 4..6.
REQ-011 pic_width_in_luma_samples  in  14; pic_height_in_luma_samples  in  13; both quasi-static.
REQ-012 mem_wr_val  out  1  one row write is pending.
REQ-013 mem_wr_rdy  in  1  memory accepts the write when mem_wr_val and mem_wr_rdy are both high.
REQ-014 mem_wr_addr  out  27  sample address of the row's leftmost sample.
REQ-015 mem_wr_data  out  bitDepthY*4  one row; col 0 in the LSBs.
REQ-016 busy  out  1  high when the FIFO is non-empty.

Function
REQ-017 Block origin: x = (xCtb << nMaxCUlog2) + (xTb_rela << 2) and y = (yCtb << nMaxCUlog2) + (yTb_rela << 2), computed at acceptance with no overflow at 27 bits.
REQ-018 Base address: base = y*pic_width_in_luma_samples + x, computed and stored with the block at acceptance.
REQ-019 recon_rdy = (count < FIFO_DEPTH), from registered state only; it does not depend combinationally on mem_wr_rdy.
REQ-020 Out-of-picture block: an accepted block with x >= width or y >= height is consumed and discarded, never stored and never written.
REQ-021 Drain state machine has two states.
- IDLE: FIFO empty, mem_wr_val = 0.
- WRITE: head block present; row counter r = 0..3; mem_wr_val = 1.
REQ-022 In WRITE, mem_wr_addr = base + r*pic_width_in_luma_samples and mem_wr_data = head row r.
REQ-023 A write handshake increments r; a handshake at r = 3 pops the head and resets r to 0.
REQ-024 After the pop: go to IDLE if the FIFO is empty, else stay in WRITE on the next block with no bubble cycle.
REQ-025 mem_wr_val, mem_wr_addr and mem_wr_data are registered outputs and hold stable while mem_wr_val is high and mem_wr_rdy is low.
REQ-026 Latency: a block accepted at edge N into an empty FIFO drives its row 0 write from edge N+1.
REQ-027 Throughput: one block per 4 cycles when mem_wr_rdy is held high.
REQ-028 Simultaneous push and pop in the same cycle leaves count unchanged; the FIFO pointers wrap modulo FIFO_DEPTH.
REQ-029 count ranges 0..FIFO_DEPTH; it never overflows because recon_rdy is low when full.

Reset
REQ-030 While rst is high at an edge, all state clears regardless of other inputs, including mid-block:
- count = 0, pointers = 0, r = 0, state = IDLE
- mem_wr_val = 0, mem_wr_addr = 0, mem_wr_data = 0, busy = 0
REQ-031 In the cycle after reset deasserts, recon_rdy = 1. Partial blocks are lost and never resumed.

Structure
REQ-032 Shared package intra_pkg holds:
- bitDepthY default
- ADDR_W = 27
- ROWS_PER_BLK = 4
- the FIFO entry layout: data, base address
REQ-033 Sub-module recon_blk_fifo: synchronous FIFO with parameters width and depth, providing push, pop, count, full and empty. The top holds the address arithmetic and the drain state machine.

Verification
REQ-034 Single block: width = 64, height = 64, nMaxCUlog2 = 6, xCtb = 0, yCtb = 0, xTb_rela = 1, yTb_rela = 2, mem_wr_rdy = 1 -> four writes at addr 516, 580, 644, 708 on consecutive cycles; busy falls afterwards.
REQ-035 Backpressure: mem_wr_rdy = 0 for 10 cycles with 6 blocks offered (FIFO_DEPTH = 4) -> recon_rdy falls after 4 accepts; mem_wr outputs stay stable; all 4 accepted blocks drain in order once mem_wr_rdy = 1; the 16 writes match the reference model.
REQ-036 Clipping: width = 72, xCtb = 1, nMaxCUlog2 = 6, xTb_rela = 2 (x = 72) -> block accepted, zero writes, count stays 0.
REQ-037 Streaming: 8 back-to-back blocks with mem_wr_rdy = 1 -> 32 writes with no idle cycle between blocks; count never exceeds 2.
REQ-038 Reset mid-block: rst asserted after row 1 of a block is written -> next cycle mem_wr_val = 0, busy = 0, recon_rdy = 1; rows 2..3 are never written.
